// File: rtl/aes_key_sched_ctrl.sv
`timescale 1ns/1ps
// Iterative AES-128 key schedule: one shared g-function, 11 round keys held in a register file.
// Optional macro AES_KEYSCHED_REUSE_EN skips re-expansion when the same key is resubmitted in DONE.
module aes_key_sched_ctrl #(
  parameter int READ_REG = 1,
  parameter int NR       = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  if (NR != 10) begin : g_nr_check
    $error("aes_key_sched_ctrl supports only NR = 10");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as the affine map of the GF(2^8) inverse (x^254, with 0 -> 0).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     round_q, round_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [127:0]   cur_q, cur_d;
  logic           key_ready_q, key_ready_d;
  logic           busy_q, busy_d;
  logic           keys_valid_q, keys_valid_d;
  logic           wr_en;
  logic [3:0]     wr_idx;
  logic [127:0]   wr_data;
  logic [127:0]   rk_q [0:NR];

  logic [31:0]    w0, w1, w2, w3, g, n0, n1, n2, n3;
  logic [127:0]   next_rk;
  logic           accept;
  logic           reuse_hit;

  // cur_q mirrors rk[round-1], so the g-function never needs an indexed read.
  always_comb begin
    w0 = cur_q[31:0];
    w1 = cur_q[63:32];
    w2 = cur_q[95:64];
    w3 = cur_q[127:96];
    g  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon_q, 24'h0};
    n0 = w0 ^ g;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_rk = {n3, n2, n1, n0};
  end

  assign accept = key_valid && key_ready_q;

`ifdef AES_KEYSCHED_REUSE_EN
  assign reuse_hit = (state_q == DONE) && (key_in == rk_q[0]);
`else
  assign reuse_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    rcon_d       = rcon_q;
    cur_d        = cur_q;
    key_ready_d  = key_ready_q;
    busy_d       = busy_q;
    keys_valid_d = keys_valid_q;
    wr_en        = 1'b0;
    wr_idx       = round_q;
    wr_data      = next_rk;
    case (state_q)
      IDLE, DONE: begin
        if (accept && !reuse_hit) begin
          wr_en        = 1'b1;
          wr_idx       = 4'd0;
          wr_data      = key_in;
          cur_d        = key_in;
          round_d      = 4'd1;
          rcon_d       = 8'h01;
          state_d      = EXPAND;
          key_ready_d  = 1'b0;
          busy_d       = 1'b1;
          keys_valid_d = 1'b0;
        end
      end
      EXPAND: begin
        wr_en  = 1'b1;
        cur_d  = next_rk;
        rcon_d = xtime(rcon_q);
        if (round_q == 4'(NR)) begin
          state_d      = DONE;
          key_ready_d  = 1'b1;
          busy_d       = 1'b0;
          keys_valid_d = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      round_q      <= '0;
      rcon_q       <= '0;
      cur_q        <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      cur_q        <= cur_d;
      key_ready_q  <= key_ready_d;
      busy_q       <= busy_d;
      keys_valid_q <= keys_valid_d;
      for (int i = 0; i <= NR; i++) begin
        if (wr_en && wr_idx == 4'(i)) rk_q[i] <= wr_data;
      end
    end
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;

  logic [127:0] rd_key_d;
  logic         rd_err_d;

  always_comb begin
    rd_key_d = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_round == 4'(i)) rd_key_d = rk_q[i];
    end
    rd_err_d = rd_round > 4'(NR);
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [127:0] rd_key_q;
    logic         rd_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_key_q <= '0;
        rd_err_q <= 1'b0;
      end else begin
        rd_key_q <= rd_key_d;
        rd_err_q <= rd_err_d;
      end
    end
    assign rd_key = rd_key_q;
    assign rd_err = rd_err_q;
  end else begin : g_rd_comb
    assign rd_key = rd_key_d;
    assign rd_err = rd_err_d;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller for the encryption path. It accepts a 128-bit cipher key through a valid/ready handshake and sequences a single shared g-function (RotWord, SubWord, Rcon) over 10 cycles. The 11 round keys go into an internal register file, and the round sequencer reads them by index. It replaces the fully unrolled combinational expansion with one g-function instance.

## Interface
Parameters:
- READ_REG, 1: 1 = registered read port (1-cycle latency); 0 = combinational read.
- NR, 10: number of rounds; only 10 is supported, and any other value is an elaboration error.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- key_in, in, 128: cipher key; word0 = key_in[31:0], word3 = key_in[127:96].
- key_valid, in, 1: key_in is valid.
- key_ready, out, 1: controller can accept a key.
- busy, out, 1: expansion in progress.
- keys_valid, out, 1: all 11 round keys are stored and consistent.
- rd_round, in, 4: round-key index, 0..10.
- rd_key, out, 128: round key rd_round, as {w[4N+3], w[4N+2], w[4N+1], w[4N]}.
- rd_err, out, 1: rd_round > 10.

## Operation
- FSM states: IDLE, EXPAND, DONE. Reset state is IDLE.
- key_ready = 1 in IDLE and DONE, 0 in EXPAND.
- Accept: key_valid && key_ready at a rising edge.
  - rk[0] <= key_in; round <= 1; rcon <= 8'h01; state <= EXPAND.
  - keys_valid <= 0 on the same edge.
- EXPAND, each edge:
  - g = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where w3 = rk[round-1][127:96] and RotWord maps {b3,b2,b1,b0} to {b2,b1,b0,b3}.
  - n0 = w0 ^ g, n1 = w1 ^ n0, n2 = w2 ^ n1, n3 = w3 ^ n2.
  - rk[round] <= {n3, n2, n1, n0}.
  - rcon <= xtime(rcon): shift left by 1, XOR 8'h1b if bit 7 was set.
  - round <= round + 1.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- When round == 10 is written: state <= DONE, keys_valid <= 1, busy <= 0.
- busy = 1 exactly while in EXPAND.
- key_valid in EXPAND is ignored. The key is not captured, and the sender must hold it until key_ready.
- A new key accepted in DONE restarts the expansion.
- Reads:
  - rd_round 0..10 returns the stored rk; rd_err = 0.
  - rd_round 11..15 returns rd_key = 0; rd_err = 1.
  - Reads during EXPAND return current storage, which may be stale. Consumers must gate on keys_valid.
- All arithmetic is bitwise XOR, with no carries. round is a 4-bit counter and never wraps, because it leaves EXPAND at 10.

## Timing
- Reset (async assert, deasserted synchronously by the system):
  - state = IDLE, key_ready = 1, busy = 0, keys_valid = 0.
  - all rk = 0, rd_key = 0, rd_err = 0, round = 0, rcon = 0.
- Accept edge E0, then rk[n] is written at edge En. keys_valid and key_ready are high after E10.
  - Latency from accept to keys_valid is 10 cycles.
- busy rises after E0 and falls after E10.
- Read latency:
  - READ_REG = 1: rd_key and rd_err valid on the edge after rd_round.
  - READ_REG = 0: same cycle.
  - If the read and the rk write fall on the same edge, a registered read returns the old value.
- Reset mid-EXPAND: immediate return to reset values. The partial schedule is discarded.
- Back-to-back: a key accepted on the cycle keys_valid rises is allowed. keys_valid drops at that accept edge.

## Configuration
- AES_KEYSCHED_REUSE_EN:
  - Defined: on accept in DONE with key_in == rk[0], the state stays DONE, keys_valid stays 1, storage is unchanged, and busy never rises.
  - Undefined: every accepted key re-runs the full 10-cycle expansion, identical keys included.

## Test plan
- Reset: assert rst_n = 0 mid-EXPAND (after E4) -> all outputs at reset values immediately; rd_round = 5 after release reads 0.
- All-zero key accepted -> keys_valid rises exactly 10 cycles later; rd_round = 1 -> rd_key = 128'h62636363_62636363_62636363_62636363; rd_round = 0 -> 0.
- Random keys versus a golden model using the same word ordering -> rk[0..10] match for 50 keys; rcon trace matches 01..36.
- key_valid held during EXPAND with a different key -> ignored; key_ready = 0; stored schedule matches the first key only.
- rd_round = 11 and 15 -> rd_key = 0, rd_err = 1; rd_round = 10 -> rd_err = 0; latency matches READ_REG (0 and 1 both built).
- Same key resubmitted in DONE:
  - with AES_KEYSCHED_REUSE_EN -> busy stays 0, keys_valid stays 1;
  - without -> keys_valid drops for 10 cycles, then identical rk values.
